// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state encoding and command layout shared by the ALU issue queue.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CMD_OPW = 4;

    typedef struct packed {
        logic [CMD_OPW-1:0] a;
        logic [CMD_OPW-1:0] b;
        logic [2:0]         op;
    } cmd_t;

    function automatic logic is_supported_op(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with occupancy count and a synchronous flush.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rp_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= do_push ? wp_q + 1'b1 : wp_q;
            rp_q  <= do_pop ? rp_q + 1'b1 : rp_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues them one at a time and registers each result
// (or an error for unsupported ops / divide by zero) for a valid/ready consumer.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = 4,
    parameter int RW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPW-1:0]         in_a,
    input  logic [OPW-1:0]         in_b,
    input  logic [2:0]             in_op,
    output logic [OPW-1:0]         alu_a,
    output logic [OPW-1:0]         alu_b,
    output logic [2:0]             alu_op,
    input  logic [RW-1:0]          alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RW-1:0]          out_result,
    output logic [2:0]             out_op,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = 2 * OPW + 3;

    logic [CW-1:0]  head;
    logic           full, empty, exec, done_ack, issue, bad;
    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]     op_q, op_d, oop_q, oop_d;
    logic           ov_q, ov_d, err_q, err_d;
    logic [RW-1:0]  res_q, res_d;

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in_valid),
        .pop   (issue),
        .din   ({in_a, in_b, in_op}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready = !full;
    assign exec     = state_q == S_EXEC;
    assign done_ack = state_q == S_DONE && ov_q && out_ready;
    assign issue    = !empty && (state_q == S_IDLE || done_ack);
    // alu_result is meaningless for these cases, so it is replaced by zero
    assign bad      = !is_supported_op(op_q) || (op_q == OP_DIV && b_q == '0);

    always_comb begin
        state_d            = issue ? S_EXEC : exec ? S_DONE : done_ack ? S_IDLE : state_q;
        {a_d, b_d, op_d}   = issue ? head : {a_q, b_q, op_q};
        ov_d               = exec ? 1'b1 : done_ack ? 1'b0 : ov_q;
        res_d              = exec ? (bad ? '0 : alu_result) : res_q;
        oop_d              = exec ? op_q : oop_q;
        err_d              = exec ? bad : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            oop_q   <= '0;
            err_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            ov_q    <= 1'b0;
            res_q   <= '0;
            oop_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            oop_q   <= oop_d;
            err_q   <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign out_valid  = ov_q;
    assign out_result = res_q;
    assign out_op     = oop_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scenarios against a behavioural 4-bit ALU with hand-computed results.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int OPW   = 4;
    localparam int RW    = 8;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [OPW-1:0] in_a = '0, in_b = '0;
    logic [2:0] in_op = '0;
    logic in_ready, out_valid, out_err;
    logic [OPW-1:0] alu_a, alu_b;
    logic [2:0] alu_op, out_op;
    logic [RW-1:0] alu_result, out_result;
    logic [$clog2(DEPTH):0] count;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // Garbage on div-by-zero and unsupported ops so that passing it through would be visible
    always_comb
        alu_result = alu_op == OP_ADD ? RW'(alu_a) + RW'(alu_b) :
                     alu_op == OP_SUB ? RW'(alu_a) - RW'(alu_b) :
                     alu_op == OP_MUL ? RW'(alu_a) * RW'(alu_b) :
                     alu_op == OP_DIV ? (alu_b == '0 ? 8'hFF : RW'(alu_a / alu_b)) : 8'h5A;

    alu_issue_queue #(.DEPTH(DEPTH), .OPW(OPW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_err(out_err), .count(count)
    );

    task automatic drive(input cmd_t c);
        in_a = c.a;
        in_b = c.b;
        in_op = c.op;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({alu_a, alu_b, alu_op, out_valid, out_result, out_op, out_err, count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {alu_a, alu_b, alu_op, out_valid, out_result, out_op, out_err, count});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 1_0_000", {in_ready, out_valid, count});
        end
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        drive(cmd_t'{4'd3, 4'd5, OP_ADD});
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({count, alu_a} !== {3'd1, 4'd0}) begin
            n_bad++;
            $display("FAIL add_push: got %h want 10", {count, alu_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({alu_a, alu_b, alu_op, out_valid, count} !== {4'd3, 4'd5, OP_ADD, 1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL add_issue: got %h want %h", {alu_a, alu_b, alu_op, out_valid, count}, {4'd3, 4'd5, OP_ADD, 1'b0, 3'd0});
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_result, out_op, out_err} !== {1'b1, 8'h08, OP_ADD, 1'b0}) begin
            n_bad++;
            $display("FAIL add_result: got %h want %h", {out_valid, out_result, out_op, out_err}, {1'b1, 8'h08, OP_ADD, 1'b0});
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, alu_a, alu_b} !== {1'b0, 4'd3, 4'd5}) begin
            n_bad++;
            $display("FAIL add_retire: got %h want 035", {out_valid, alu_a, alu_b});
        end
    endtask

    task automatic test_back_to_back;
        cmd_t c[3];
        logic [7:0] r[3];
        c = '{cmd_t'{4'd3, 4'd5, OP_SUB}, cmd_t'{4'd15, 4'd15, OP_MUL}, cmd_t'{4'd9, 4'd2, OP_DIV}};
        r = '{8'hFE, 8'hE1, 8'h04};
        for (int i = 0; i < 3; i++) begin
            drive(c[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({out_valid, out_result, out_op, out_err} !== {1'b1, r[i], c[i].op, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_result%0d: got %h want %h", i, {out_valid, out_result, out_op, out_err}, {1'b1, r[i], c[i].op, 1'b0});
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_gap%0d: got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_errors;
        cmd_t c[2];
        c = '{cmd_t'{4'd7, 4'd0, OP_DIV}, cmd_t'{4'd1, 4'd1, 3'b101}};
        for (int i = 0; i < 2; i++) begin
            drive(c[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
            n_cmp++;
            if ({out_valid, out_result, out_op, out_err} !== {1'b1, 8'h00, c[i].op, 1'b1}) begin
                n_bad++;
                $display("FAIL err_result%0d: got %h want %h", i, {out_valid, out_result, out_op, out_err}, {1'b1, 8'h00, c[i].op, 1'b1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        cmd_t c[5];
        logic [7:0] r[5];
        int seen = 0;
        c = '{cmd_t'{4'd1, 4'd2, OP_ADD}, cmd_t'{4'd9, 4'd4, OP_SUB}, cmd_t'{4'd3, 4'd4, OP_MUL},
              cmd_t'{4'd15, 4'd3, OP_DIV}, cmd_t'{4'd6, 4'd6, OP_ADD}};
        r = '{8'h03, 8'h05, 8'h0C, 8'h05, 8'h0C};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(c[i]);
            @(negedge clk);
        end
        n_cmp++;
        if ({count, in_ready, out_valid, out_result} !== {3'd4, 1'b0, 1'b1, 8'h03}) begin
            n_bad++;
            $display("FAIL bp_full: got %h want %h", {count, in_ready, out_valid, out_result}, {3'd4, 1'b0, 1'b1, 8'h03});
        end
        drive(cmd_t'{4'd2, 4'd2, OP_ADD});
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({count, out_valid, out_result, out_op, out_err} !== {3'd4, 1'b1, 8'h03, OP_ADD, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_hold: got %h want %h", {count, out_valid, out_result, out_op, out_err}, {3'd4, 1'b1, 8'h03, OP_ADD, 1'b0});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
            n_cmp++;
            if ({out_valid, out_result, out_op} !== {1'b1, r[i], c[i].op}) begin
                n_bad++;
                $display("FAIL bp_result%0d: got %h want %h", i, {out_valid, out_result, out_op}, {1'b1, r[i], c[i].op});
            end
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if ({in_ready, count} !== {1'b1, 3'd3}) begin
                    n_bad++;
                    $display("FAIL bp_ready: got %b want 1_011", {in_ready, count});
                end
            end
        end
        repeat (6) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL bp_dropped_push: got %0d extra results want 0", seen);
        end
    endtask

    task automatic test_flush;
        cmd_t c[4];
        int seen = 0;
        c = '{cmd_t'{4'd1, 4'd1, 3'b111}, cmd_t'{4'd1, 4'd2, OP_ADD}, cmd_t'{4'd3, 4'd3, OP_ADD}, cmd_t'{4'd4, 4'd4, OP_ADD}};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(c[i]);
            @(negedge clk);
        end
        n_cmp++;
        if ({count, out_valid, out_err} !== {3'd3, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_setup: got %b want 011_1_1", {count, out_valid, out_err});
        end
        drive(cmd_t'{4'd5, 4'd5, OP_ADD});
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({count, out_valid, out_err, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_clear: got %b want 000_0_0_1", {count, out_valid, out_err, in_ready});
        end
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL flush_quiet: got %0d results want 0", seen);
        end
        drive(cmd_t'{4'd4, 4'd3, OP_SUB});
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_result, out_op, out_err} !== {1'b1, 8'h01, OP_SUB, 1'b0}) begin
            n_bad++;
            $display("FAIL flush_after: got %h want %h", {out_valid, out_result, out_op, out_err}, {1'b1, 8'h01, OP_SUB, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        cmd_t c[4];
        c = '{cmd_t'{4'd1, 4'd1, OP_ADD}, cmd_t'{4'd2, 4'd3, OP_MUL}, cmd_t'{4'd7, 4'd1, OP_SUB}, cmd_t'{4'd8, 4'd2, OP_DIV}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(c[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({alu_a, alu_b, count, out_valid} !== {4'd2, 4'd3, 3'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_setup: got %h want %h", {alu_a, alu_b, count, out_valid}, {4'd2, 4'd3, 3'd2, 1'b0});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_op, out_valid, out_result, out_op, out_err, count} !== '0) begin
            n_bad++;
            $display("FAIL arst_async: got %h want 0", {alu_a, alu_b, alu_op, out_valid, out_result, out_op, out_err, count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL arst_no_partial: got %b want 0_000", {out_valid, count});
        end
        drive(cmd_t'{4'd2, 4'd2, OP_ADD});
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_result, out_op, out_err} !== {1'b1, 8'h04, OP_ADD, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_after: got %h want %h", {out_valid, out_result, out_op, out_err}, {1'b1, 8'h04, OP_ADD, 1'b0});
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_errors;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the 4-bit ALU: buffers operand/op commands from a producer through a valid/ready interface.
- Issues one command at a time on registered alu_a/alu_b/alu_op.
- Waits one settle cycle, then captures the ALU's 8-bit result into an output register, handed downstream via valid/ready.
- Screens out op codes the ALU does not implement and divide-by-zero, flagging both with out_err.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- OPW, 4, operand width (a, b).
- RW, 8, result width; must be 2*OPW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of queue, FSM and output register.
- in_valid  in  1  command valid.
- in_ready  out  1  queue can accept a command (not full).
- in_a  in  OPW  operand A.
- in_b  in  OPW  operand B.
- in_op  in  3  op: 000 add, 001 sub, 010 mul, 011 div; 100-111 unsupported.
- alu_a  out  OPW  registered operand A to ALU.
- alu_b  out  OPW  registered operand B to ALU.
- alu_op  out  3  registered op to ALU.
- alu_result  in  RW  combinational result from ALU.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  RW  captured result.
- out_op  out  3  op that produced out_result.
- out_err  out  1  unsupported op or divide by zero.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, state IDLE, alu_a/alu_b/alu_op=0, out_valid=0, out_result=0, out_op=0, out_err=0. in_ready=1 on the first cycle after release. Asserting reset mid-operation discards everything; no partial result appears.
- Push: in_valid&&in_ready at an edge writes the command. in_ready = (count<DEPTH); no bypass, so in_ready=0 when full even if a pop happens that cycle.
- Pop: occurs on entry to EXEC. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if count>0, load alu_* from head, pop, go to EXEC.
  - EXEC (exactly one cycle): at the edge, capture the result, set out_valid=1, go to DONE.
    - Supported op with no divide-by-zero: out_result=alu_result, out_err=0.
    - Op 100-111, or op 011 with alu_b==0: out_result=0, out_err=1; alu_result is ignored.
    - out_op=alu_op in all cases.
  - DONE: hold out_* stable while out_ready=0. On out_valid&&out_ready:
    - count>0: load the next head, pop, go to EXEC; out_valid=0.
    - otherwise: go to IDLE; out_valid=0.
- alu_* hold their last value in IDLE and DONE; they do not return to 0.
- Latency: command pushed into an empty, idle queue at edge E0 is issued at E1; out_valid=1 after E2. Throughput is one result per 2 cycles with out_ready held high.
- Arithmetic: the block passes alu_result through unmodified. Sub wraps in RW bits (3-5 = 8'hFE). Mul maximum is 15*15 = 8'hE1. Div truncates.
- Flush (synchronous, sampled at the edge): empties FIFO, count=0, state=IDLE, out_valid=0, out_err=0. A push in the same cycle is dropped. Flush has priority over all other events. alu_* are not cleared.
- Results emerge in command order; no reordering, no drops except by flush or reset.

Decomposition:
- Package alu_pkg:
  - op encodings OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011;
  - function is_supported_op;
  - FSM state encoding (IDLE, EXEC, DONE);
  - command struct {a, b, op}.
- Sub-module: alu_cmd_fifo, a synchronous FIFO (DEPTH, width 2*OPW+3) with push/pop/full/empty/count and flush.
- The FSM and output register stay in alu_issue_queue.

Test Plan:
- Reset, then push {a=3,b=5,op=000} with out_ready=1 -> alu_* load 1 cycle after push; out_valid=1 two cycles after push with out_result=8'h08, out_op=000, out_err=0.
- Push sub {3,5,001}, mul {15,15,010}, div {9,2,011} back-to-back with out_ready=1 -> results 8'hFE, 8'hE1, 8'h04 in order, one every 2 cycles, out_err=0.
- Push div {7,0,011} and op {1,1,101} -> both give out_result=0, out_err=1, out_op 011 then 101.
- Hold out_ready=0, push 5 commands with DEPTH=4 -> first enters the output register; count reaches 4; in_ready=0 on the extra push. Outputs stay stable. Release out_ready -> all 5 results in order; in_ready returns to 1 when count<4.
- Queue holding 3 commands, out_valid=1: assert flush for 1 cycle together with in_valid -> count=0, out_valid=0, state IDLE, pushed command dropped. No further out_valid until a new push.
- Drop rst_n asynchronously mid-EXEC with 2 queued -> outputs immediately reach reset values. After release, a push {2,2,000} yields 8'h04 two cycles later.
